// File: rtl/cache_sa_wb.sv
// Write-back, write-allocate cache with 1 or 2 ways, LRU replacement and
// valid/ack handshaking to a block-wide memory, plus saturating hit/miss counters.
module cache_sa_wb #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WPB    = 4,
    parameter int unsigned SETS   = 2,
    parameter int unsigned WAYS   = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [31:0]         cpu_wdata,
    output logic                cpu_ready,
    output logic                cpu_done,
    output logic [31:0]         cpu_rdata,
    output logic                cpu_hit,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [32*WPB-1:0]   mem_wdata,
    input  logic [32*WPB-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);
    localparam int unsigned WO  = $clog2(WPB);
    localparam int unsigned IW  = $clog2(SETS);
    localparam int unsigned IWS = (IW > 0) ? IW : 1;
    localparam int unsigned TW  = ADDR_W - 2 - WO - IW;
    localparam int unsigned BW  = 32 * WPB;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOOKUP    = 2'd1;
    localparam logic [1:0] WRITEBACK = 2'd2;
    localparam logic [1:0] ALLOCATE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              miss_q, miss_d;
    logic              victim_q, victim_d;
    logic              done_q, done_d;
    logic              hit_q, hit_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [BW-1:0]     mem_wdata_q, mem_wdata_d;

    logic [BW-1:0]     data_q  [WAYS][SETS];
    logic [TW-1:0]     tag_q   [WAYS][SETS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [SETS-1:0]   lru_q;

    logic [ADDR_W-1:0] idx_sh, tag_sh;
    logic [IWS-1:0]    idx;
    logic [TW-1:0]     req_tag;
    logic [WO-1:0]     word;
    logic              hit, hit_way, vic, vic_dirty;
    logic              fill_en, wr_en, lru_en;
    logic              unused_bits;

    assign idx_sh      = addr_q >> (2 + WO);
    assign tag_sh      = addr_q >> (2 + WO + IW);
    assign idx         = (IW == 0) ? '0 : idx_sh[IWS-1:0];
    assign req_tag     = tag_sh[TW-1:0];
    assign word        = addr_q[WO+1:2];
    assign unused_bits = ^{addr_q[1:0], idx_sh, tag_sh};

    function automatic logic [ADDR_W-1:0] blk_addr(input logic [TW-1:0] t,
                                                  input logic [IWS-1:0] i);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(t) << (2 + WO + IW);
        if (IW != 0) a = a | (ADDR_W'(i) << (2 + WO));
        return a;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[w][idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = 1'(w);
            end
        end
        // Empty ways are filled before any valid line is evicted.
        if (WAYS == 1)                    vic = 1'b0;
        else if (!valid_q[idx][0])        vic = 1'b0;
        else if (!valid_q[idx][WAYS-1])   vic = 1'b1;
        else                              vic = lru_q[idx];
        vic_dirty = valid_q[idx][vic] && dirty_q[idx][vic];
    end

    assign fill_en = (state_q == ALLOCATE) && mem_ack;
    assign wr_en   = (state_q == LOOKUP) && hit && we_q;
    assign lru_en  = (state_q == LOOKUP) && hit;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        miss_d      = miss_q;
        victim_d    = victim_q;
        done_d      = 1'b0;
        hit_d       = hit_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    miss_d  = 1'b0;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    if (!we_q) rdata_d = data_q[hit_way][idx][32*word +: 32];
                    done_d  = 1'b1;
                    hit_d   = !miss_q;
                    state_d = IDLE;
                end else begin
                    miss_d   = 1'b1;
                    victim_d = vic;
                    if (vic_dirty) begin
                        mem_addr_d  = blk_addr(tag_q[vic][idx], idx);
                        mem_wdata_d = data_q[vic][idx];
                        state_d     = WRITEBACK;
                    end else begin
                        mem_addr_d = blk_addr(req_tag, idx);
                        state_d    = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack) begin
                    mem_addr_d = blk_addr(req_tag, idx);
                    state_d    = ALLOCATE;
                end
            end
            default: begin
                if (mem_ack) state_d = LOOKUP;
            end
        endcase
        if (done_q) begin
            if (hit_q) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            miss_q      <= 1'b0;
            victim_q    <= 1'b0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            rdata_q     <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lru_q       <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            miss_q      <= miss_d;
            victim_q    <= victim_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
            rdata_q     <= rdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if (fill_en) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
            if (wr_en) dirty_q[idx][hit_way] <= 1'b1;
            if (lru_en && (WAYS == 2)) lru_q[idx] <= ~hit_way;
        end
    end

    // Data and tags carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[victim_q][idx] <= mem_rdata;
            tag_q[victim_q][idx]  <= req_tag;
        end
        if (wr_en) data_q[hit_way][idx][32*word +: 32] <= wdata_q;
    end

    assign cpu_ready = (state_q == IDLE);
    assign cpu_done  = done_q;
    assign cpu_rdata = rdata_q;
    assign cpu_hit   = hit_q;
    assign mem_req   = (state_q == WRITEBACK) || (state_q == ALLOCATE);
    assign mem_we    = (state_q == WRITEBACK);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_cache_sa_wb.sv
// Directed bench for cache_sa_wb: a default instance against a latency-controlled memory
// model, plus a 3-bit-counter instance and a direct-mapped instance on zero-wait memory.
module tb_cache_sa_wb;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         cpu_req, cpu_we, cpu_ready, cpu_done, cpu_hit;
    logic [9:0]   cpu_addr, mem_addr;
    logic [31:0]  cpu_wdata, cpu_rdata;
    logic         mem_req, mem_we;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;
    logic [15:0]  hit_cnt, miss_cnt;

    cache_sa_wb u_dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Secondary instances share one CPU stimulus and use zero-wait memory.
    logic         cpu_req_s, cpu_we_s;
    logic [9:0]   cpu_addr_s;
    logic [31:0]  cpu_wdata_s;
    logic         rdy_a, done_a, hit_a, mreq_a, mwe_a;
    logic         rdy_b, done_b, hit_b, mreq_b, mwe_b;
    logic [31:0]  rdata_a, rdata_b;
    logic [9:0]   maddr_a, maddr_b;
    logic [127:0] mwdata_a, mwdata_b, mrdata_a, mrdata_b;
    logic [2:0]   hcnt_a, mcnt_a;
    logic [15:0]  hcnt_b, mcnt_b;
    assign mrdata_a = {4{22'd0, maddr_a}};
    assign mrdata_b = {4{22'd0, maddr_b}};

    cache_sa_wb #(.CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req_s), .cpu_we(cpu_we_s),
        .cpu_addr(cpu_addr_s), .cpu_wdata(cpu_wdata_s), .cpu_ready(rdy_a),
        .cpu_done(done_a), .cpu_rdata(rdata_a), .cpu_hit(hit_a),
        .mem_req(mreq_a), .mem_we(mwe_a), .mem_addr(maddr_a), .mem_wdata(mwdata_a),
        .mem_rdata(mrdata_a), .mem_ack(mreq_a), .hit_cnt(hcnt_a), .miss_cnt(mcnt_a)
    );

    cache_sa_wb #(.WAYS(1), .SETS(4)) u_dm (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req_s), .cpu_we(cpu_we_s),
        .cpu_addr(cpu_addr_s), .cpu_wdata(cpu_wdata_s), .cpu_ready(rdy_b),
        .cpu_done(done_b), .cpu_rdata(rdata_b), .cpu_hit(hit_b),
        .mem_req(mreq_b), .mem_we(mwe_b), .mem_addr(maddr_b), .mem_wdata(mwdata_b),
        .mem_rdata(mrdata_b), .mem_ack(mreq_b), .hit_cnt(hcnt_b), .miss_cnt(mcnt_b)
    );

    // Main memory model: block b word w initially 0xB000_0000 | b<<8 | w.
    logic [127:0] mem_blk [64];
    int           lat = 0;
    int           wcnt = 0;
    int           fill_cnt = 0, wb_cnt = 0;
    logic [9:0]   last_fill_addr = '0, last_wb_addr = '0;
    logic [127:0] last_wb_data = '0;

    initial begin
        for (int b = 0; b < 64; b++) begin
            logic [127:0] v;
            for (int w = 0; w < 4; w++) v[32*w +: 32] = 32'hB000_0000 | 32'(b << 8) | 32'(w);
            mem_blk[b] <= v;
        end
    end

    always @(negedge clk) begin
        if (mem_req && wcnt >= lat) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_blk[mem_addr[9:4]];
            wcnt      = 0;
        end else begin
            mem_ack = 1'b0;
            if (mem_req) wcnt = wcnt + 1;
            else         wcnt = 0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && mem_req && mem_ack) begin
            if (mem_we) begin
                mem_blk[mem_addr[9:4]] <= mem_wdata;
                wb_cnt       <= wb_cnt + 1;
                last_wb_addr <= mem_addr;
                last_wb_data <= mem_wdata;
            end else begin
                fill_cnt       <= fill_cnt + 1;
                last_fill_addr <= mem_addr;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    // Issue one request at a negedge; returns at the negedge where cpu_done is high.
    task automatic access(input logic we, input logic [9:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic hit, output int cyc);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        cyc = 1;
        while (!cpu_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!cpu_done) begin
            errors++;
            $display("FAIL done_timeout addr=%h: no cpu_done within %0d cycles", a, cyc);
        end
        rd = cpu_rdata;
        hit = cpu_hit;
    endtask

    task automatic access_s(input logic [9:0] a, output logic [31:0] rda, output logic [31:0] rdb,
                            output logic ha, output logic hb);
        bit ga, gb;
        int cyc;
        cpu_req_s = 1'b1; cpu_we_s = 1'b0; cpu_addr_s = a; cpu_wdata_s = '0;
        @(posedge clk);
        @(negedge clk);
        cpu_req_s = 1'b0;
        cyc = 1; ga = 0; gb = 0; rda = 'x; rdb = 'x; ha = 1'bx; hb = 1'bx;
        while (!(ga && gb) && cyc < 100) begin
            if (done_a && !ga) begin ga = 1; rda = rdata_a; ha = hit_a; end
            if (done_b && !gb) begin gb = 1; rdb = rdata_b; hb = hit_b; end
            if (!(ga && gb)) begin @(negedge clk); cyc++; end
        end
        checks++;
        if (!(ga && gb)) begin
            errors++;
            $display("FAIL sec_done_timeout addr=%h: got done_a=%0d done_b=%0d", a, ga, gb);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_mem: got req=%b we=%b expected 0 0", mem_req, mem_we);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu_ready, cpu_done, cpu_hit} !== 3'b100) begin
            errors++; $display("FAIL reset_flags: got rdy/done/hit=%b expected 100",
                               {cpu_ready, cpu_done, cpu_hit});
        end
        checks++;
        if (cpu_rdata !== 32'h0 || hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
            errors++; $display("FAIL reset_regs: got rdata=%h hit=%h miss=%h expected 0",
                               cpu_rdata, hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_read_miss_hit();
        logic [31:0] rd; logic hit; int cyc; int f0, w0;
        lat = 0; f0 = fill_cnt; w0 = wb_cnt;
        access(1'b0, 10'h010, 32'h0, rd, hit, cyc);
        checks++;
        if (rd !== 32'hB000_0100 || hit !== 1'b0 || cyc != 4) begin
            errors++; $display("FAIL read_miss: got rd=%h hit=%b cyc=%0d expected b0000100 0 4",
                               rd, hit, cyc);
        end
        checks++;
        if (fill_cnt != f0 + 1 || wb_cnt != w0 || last_fill_addr !== 10'h010) begin
            errors++; $display("FAIL read_miss_mem: got fills=%0d wbs=%0d addr=%h expected %0d %0d 010",
                               fill_cnt - f0, wb_cnt - w0, last_fill_addr, 1, 0);
        end
        access(1'b0, 10'h014, 32'h0, rd, hit, cyc);
        checks++;
        if (rd !== 32'hB000_0101 || hit !== 1'b1 || cyc != 2 || fill_cnt != f0 + 1) begin
            errors++; $display("FAIL read_hit: got rd=%h hit=%b cyc=%0d fills=%0d expected b0000101 1 2 1",
                               rd, hit, cyc, fill_cnt - f0);
        end
        @(negedge clk);
        checks++;
        if (cpu_done !== 1'b0 || cpu_rdata !== 32'hB000_0101) begin
            errors++; $display("FAIL done_pulse: got done=%b rdata=%h expected 0 b0000101",
                               cpu_done, cpu_rdata);
        end
    endtask

    task automatic test_writeback();
        logic [31:0] rd; logic hit; int cyc; int w0;
        w0 = wb_cnt;
        access(1'b1, 10'h014, 32'hCAFE_F00D, rd, hit, cyc);
        checks++;
        if (hit !== 1'b1 || cyc != 2) begin
            errors++; $display("FAIL write_hit: got hit=%b cyc=%0d expected 1 2", hit, cyc);
        end
        access(1'b0, 10'h030, 32'h0, rd, hit, cyc);
        checks++;
        if (rd !== 32'hB000_0300 || hit !== 1'b0 || cyc != 4 || wb_cnt != w0) begin
            errors++; $display("FAIL way1_fill: got rd=%h hit=%b cyc=%0d wbs=%0d expected b0000300 0 4 0",
                               rd, hit, cyc, wb_cnt - w0);
        end
        access(1'b0, 10'h050, 32'h0, rd, hit, cyc);
        checks++;
        if (rd !== 32'hB000_0500 || hit !== 1'b0 || cyc != 5 || wb_cnt != w0 + 1) begin
            errors++; $display("FAIL evict: got rd=%h hit=%b cyc=%0d wbs=%0d expected b0000500 0 5 1",
                               rd, hit, cyc, wb_cnt - w0);
        end
        checks++;
        if (last_wb_addr !== 10'h010 || last_wb_data[63:0] !== 64'hCAFE_F00D_B000_0100) begin
            errors++; $display("FAIL evict_data: got addr=%h data=%h expected 010 cafef00db0000100",
                               last_wb_addr, last_wb_data[63:0]);
        end
        access(1'b0, 10'h030, 32'h0, rd, hit, cyc);
        checks++;
        if (rd !== 32'hB000_0300 || hit !== 1'b1) begin
            errors++; $display("FAIL way1_kept: got rd=%h hit=%b expected b0000300 1", rd, hit);
        end
    endtask

    task automatic test_write_miss();
        logic [31:0] rd; logic hit; int cyc; int w0;
        w0 = wb_cnt;
        access(1'b1, 10'h100, 32'h1234_5678, rd, hit, cyc);
        checks++;
        if (hit !== 1'b0 || cyc != 4 || wb_cnt != w0 || last_fill_addr !== 10'h100) begin
            errors++; $display("FAIL write_miss: got hit=%b cyc=%0d wbs=%0d fill=%h expected 0 4 0 100",
                               hit, cyc, wb_cnt - w0, last_fill_addr);
        end
        access(1'b0, 10'h100, 32'h0, rd, hit, cyc);
        checks++;
        if (rd !== 32'h1234_5678 || hit !== 1'b1) begin
            errors++; $display("FAIL write_merge: got rd=%h hit=%b expected 12345678 1", rd, hit);
        end
        access(1'b0, 10'h120, 32'h0, rd, hit, cyc);
        checks++;
        if (rd !== 32'hB000_1200 || hit !== 1'b0 || wb_cnt != w0) begin
            errors++; $display("FAIL set0_way1: got rd=%h hit=%b wbs=%0d expected b0001200 0 0",
                               rd, hit, wb_cnt - w0);
        end
    endtask

    task automatic test_latency();
        logic [31:0] rd; logic hit; int cyc, wb_cyc, al_cyc;
        logic snap_v, snap_we; logic [9:0] snap_a; logic [127:0] snap_d;
        lat = 5;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h140; cpu_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        cyc = 1; wb_cyc = 0; al_cyc = 0; snap_v = 1'b0; snap_we = 1'b0; snap_a = '0; snap_d = '0;
        while (!cpu_done && cyc < 200) begin
            checks++;
            if (cpu_ready !== 1'b0) begin
                errors++; $display("FAIL busy_ready: got %b expected 0 at cycle %0d", cpu_ready, cyc);
            end
            if (mem_req) begin
                if (mem_we) wb_cyc++; else al_cyc++;
                if (!snap_v || snap_we !== mem_we) begin
                    snap_v = 1'b1; snap_we = mem_we; snap_a = mem_addr; snap_d = mem_wdata;
                end else begin
                    checks++;
                    if (mem_addr !== snap_a || mem_wdata !== snap_d) begin
                        errors++; $display("FAIL mem_stable: got addr=%h expected %h at cycle %0d",
                                           mem_addr, snap_a, cyc);
                    end
                end
            end
            cpu_req = 1'($urandom_range(1, 0)); cpu_we = 1'($urandom_range(1, 0));
            cpu_addr = 10'($urandom); cpu_wdata = $urandom;
            @(negedge clk);
            cyc++;
        end
        cpu_req = 1'b0;
        checks++;
        if (cpu_rdata !== 32'hB000_1400 || cpu_hit !== 1'b0 || cyc != 15) begin
            errors++; $display("FAIL slow_miss: got rd=%h hit=%b cyc=%0d expected b0001400 0 15",
                               cpu_rdata, cpu_hit, cyc);
        end
        checks++;
        if (wb_cyc != 6 || al_cyc != 6) begin
            errors++; $display("FAIL slow_phases: got wb=%0d alloc=%0d expected 6 6", wb_cyc, al_cyc);
        end
        checks++;
        if (last_wb_addr !== 10'h100 || last_wb_data[31:0] !== 32'h1234_5678
            || last_fill_addr !== 10'h140) begin
            errors++; $display("FAIL slow_wb: got addr=%h data=%h fill=%h expected 100 12345678 140",
                               last_wb_addr, last_wb_data[31:0], last_fill_addr);
        end
        lat = 0;
        access(1'b0, 10'h144, 32'h0, rd, hit, cyc);
        checks++;
        if (rd !== 32'hB000_1401 || hit !== 1'b1 || cyc != 2) begin
            errors++; $display("FAIL post_slow_hit: got rd=%h hit=%b cyc=%0d expected b0001401 1 2",
                               rd, hit, cyc);
        end
    endtask

    task automatic test_counters();
        @(negedge clk);
        checks++;
        if (hit_cnt !== 16'd5 || miss_cnt !== 16'd6) begin
            errors++; $display("FAIL counters: got hit=%0d miss=%0d expected 5 6", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_reset_mid_wb();
        logic [31:0] rd; logic hit; int cyc;
        lat = 0;
        access(1'b1, 10'h120, 32'hDEAD_BEEF, rd, hit, cyc);
        access(1'b0, 10'h140, 32'h0, rd, hit, cyc);
        checks++;
        if (hit !== 1'b1) begin
            errors++; $display("FAIL prep_hit: got %b expected 1", hit);
        end
        lat = 5;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h160;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        cyc = 0;
        while (!(mem_req && mem_we) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!(mem_req && mem_we) || mem_addr !== 10'h120 || mem_wdata[31:0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL dirty_wb: got req=%b we=%b addr=%h data=%h expected 1 1 120 deadbeef",
                               mem_req, mem_we, mem_addr, mem_wdata[31:0]);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || cpu_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset: got req=%b we=%b rdy=%b expected 0 0 1",
                               mem_req, mem_we, cpu_ready);
        end
        checks++;
        if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || cpu_done !== 1'b0) begin
            errors++; $display("FAIL reset_counts: got hit=%0d miss=%0d done=%b expected 0 0 0",
                               hit_cnt, miss_cnt, cpu_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        access(1'b0, 10'h140, 32'h0, rd, hit, cyc);
        checks++;
        if (rd !== 32'hB000_1400 || hit !== 1'b0 || cyc != 4) begin
            errors++; $display("FAIL reread_miss: got rd=%h hit=%b cyc=%0d expected b0001400 0 4",
                               rd, hit, cyc);
        end
        access(1'b0, 10'h120, 32'h0, rd, hit, cyc);
        checks++;
        if (rd !== 32'hB000_1200 || hit !== 1'b0) begin
            errors++; $display("FAIL dirty_dropped: got rd=%h hit=%b expected b0001200 0", rd, hit);
        end
    endtask

    task automatic test_saturation_thrash();
        logic [31:0] ra, rb; logic ha, hb;
        logic [9:0] thr [4];
        logic [3:0] exp_ha;
        thr[0] = 10'h010; thr[1] = 10'h050; thr[2] = 10'h010; thr[3] = 10'h050;
        exp_ha = 4'b1100;
        for (int i = 0; i < 10; i++) begin
            access_s(10'h000, ra, rb, ha, hb);
            checks++;
            if (ha !== (i != 0) || hb !== (i != 0) || ra !== 32'h0 || rb !== 32'h0) begin
                errors++; $display("FAIL sat_access%0d: got ha=%b hb=%b ra=%h rb=%h expected %0d %0d 0 0",
                                   i, ha, hb, ra, rb, i != 0, i != 0);
            end
        end
        @(negedge clk);
        checks++;
        if (hcnt_a !== 3'd7 || mcnt_a !== 3'd1 || hcnt_b !== 16'd9 || mcnt_b !== 16'd1) begin
            errors++; $display("FAIL sat_counts: got a=%0d/%0d b=%0d/%0d expected 7/1 9/1",
                               hcnt_a, mcnt_a, hcnt_b, mcnt_b);
        end
        for (int i = 0; i < 4; i++) begin
            access_s(thr[i], ra, rb, ha, hb);
            checks++;
            if (hb !== 1'b0 || rb !== {22'd0, thr[i]} || ha !== exp_ha[i]) begin
                errors++; $display("FAIL thrash%0d: got hb=%b rb=%h ha=%b expected 0 %h %b",
                                   i, hb, rb, ha, {22'd0, thr[i]}, exp_ha[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (mcnt_b !== 16'd5 || hcnt_a !== 3'd7 || mcnt_a !== 3'd3) begin
            errors++; $display("FAIL thrash_counts: got miss_b=%0d hit_a=%0d miss_a=%0d expected 5 7 3",
                               mcnt_b, hcnt_a, mcnt_a);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_req_s = 1'b0; cpu_we_s = 1'b0; cpu_addr_s = '0; cpu_wdata_s = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_read_miss_hit();
        test_writeback();
        test_write_miss();
        test_latency();
        test_counters();
        test_reset_mid_wb();
        test_saturation_thrash();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
